// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if
// Bundles the requester handshake (start/done plus operands and result) and
// the time-shared 1-bit dual full-adder connection of serial_add_ctrl.
//   master : requester / environment view (drives request, models the adder)
//   slave  : controller view (serial_add_ctrl)
// Signals:
//   start, op_a, op_b, cin          request and operands
//   busy, done, result, cout        status and sum
//   mismatch                        sticky adder cross-check flag
//   add_a, add_b, add_cin           bit-slice operands to the adder pair
//   add_sum1, add_cout1             primary adder outputs
//   add_sum2, add_cout2             checked adder outputs
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             mismatch;
    logic             add_a;
    logic             add_b;
    logic             add_cin;
    logic             add_sum1;
    logic             add_cout1;
    logic             add_sum2;
    logic             add_cout2;

    modport master (
        output start, op_a, op_b, cin,
        input  busy, done, result, cout, mismatch,
        input  add_a, add_b, add_cin,
        output add_sum1, add_cout1, add_sum2, add_cout2
    );

    modport slave (
        input  start, op_a, op_b, cin,
        output busy, done, result, cout, mismatch,
        output add_a, add_b, add_cin,
        input  add_sum1, add_cout1, add_sum2, add_cout2
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Bit-serial WIDTH-bit adder sequencer. Feeds one operand bit per clock (LSB
// first) into an external dual-implementation 1-bit full adder, keeps the
// ripple carry in a flip-flop, assembles the sum from the primary outputs and
// flags any bit where the two adder implementations disagree.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   serial_add_ctrl_if.slave (request/result handshake + adder link)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; adder inputs held at 0
// RUN    | one operand bit per cycle through the adder, WIDTH cycles
// DONE   | one-cycle done pulse, result/cout valid; back to IDLE
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             mismatch_q, mismatch_d;

    logic [WIDTH-1:0] sum_next;
    logic             bit_err;
    logic             in_run;

    // Sum bits enter at the MSB and walk down, so after WIDTH shifts bit 0
    // of the result sits in position 0.
    assign sum_next = (sum_sh_q >> 1) | (WIDTH'(bus.add_sum1) << (WIDTH - 1));
    assign bit_err  = (bus.add_sum1 ^ bus.add_sum2) | (bus.add_cout1 ^ bus.add_cout2);
    assign in_run   = (state_q == S_RUN);

    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        sum_sh_d   = sum_sh_q;
        result_d   = result_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        cout_d     = cout_q;
        mismatch_d = mismatch_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sh_d     = bus.op_a;
                    b_sh_d     = bus.op_b;
                    carry_d    = bus.cin;
                    sum_sh_d   = '0;
                    cnt_d      = '0;
                    mismatch_d = 1'b0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                sum_sh_d   = sum_next;
                carry_d    = bus.add_cout1;
                a_sh_d     = a_sh_q >> 1;
                b_sh_d     = b_sh_q >> 1;
                mismatch_d = mismatch_q | bit_err;
                cnt_d      = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    result_d = sum_next;
                    cout_d   = bus.add_cout1;
                    cnt_d    = '0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            sum_sh_q   <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            cout_q     <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            sum_sh_q   <= sum_sh_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            cout_q     <= cout_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign bus.busy     = in_run;
    assign bus.done     = (state_q == S_DONE);
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.mismatch = mismatch_q;
    assign bus.add_a    = in_run & a_sh_q[0];
    assign bus.add_b    = in_run & b_sh_q[0];
    assign bus.add_cin  = in_run & carry_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;
    logic clk;
    logic rst;
    bit   inj8;
    int   n_assert;
    int   n_fail;

    serial_add_ctrl_if #(.WIDTH(8)) if8 ();
    serial_add_ctrl_if #(.WIDTH(1)) if1 ();

    serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    // Behavioural dual full adder; implementation 2 can be corrupted on sum.
    assign if8.add_sum1  = if8.add_a ^ if8.add_b ^ if8.add_cin;
    assign if8.add_cout1 = (if8.add_a & if8.add_b) | (if8.add_cin & (if8.add_a | if8.add_b));
    assign if8.add_sum2  = (if8.add_a ^ if8.add_b ^ if8.add_cin) ^ inj8;
    assign if8.add_cout2 = (if8.add_a & if8.add_b) | (if8.add_cin & (if8.add_a | if8.add_b));

    assign if1.add_sum1  = if1.add_a ^ if1.add_b ^ if1.add_cin;
    assign if1.add_cout1 = (if1.add_a & if1.add_b) | (if1.add_cin & (if1.add_a | if1.add_b));
    assign if1.add_sum2  = if1.add_a ^ if1.add_b ^ if1.add_cin;
    assign if1.add_cout2 = (if1.add_a & if1.add_b) | (if1.add_cin & (if1.add_a | if1.add_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation. inj_bit >= 0 corrupts Sum2 while that bit is in
    // the adder; poke fires a second start with other operands mid-run.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input int inj_bit, input bit poke);
        int   total;
        int   done_at;
        int   busy_n;
        int   mask;
        int   carry_in;
        logic exp_mm;
        total  = int'(a) + int'(b) + int'(c);
        exp_mm = (inj_bit >= 0) && (inj_bit < 8);
        @(negedge clk);
        if8.op_a  = a;
        if8.op_b  = b;
        if8.cin   = c;
        if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        if8.op_a  = 8'($urandom);
        if8.op_b  = 8'($urandom);
        if8.cin   = 1'($urandom);
        done_at = -1;
        busy_n  = 0;
        for (int n = 0; n < 14; n++) begin
            if (if8.done) begin
                done_at = n;
                break;
            end
            if (if8.busy) busy_n++;
            if (n < 8) begin
                mask     = (1 << n) - 1;
                carry_in = (((int'(a) & mask) + (int'(b) & mask) + int'(c)) >> n) & 1;
                check("add_a", 64'(if8.add_a), 64'((int'(a) >> n) & 1));
                check("add_b", 64'(if8.add_b), 64'((int'(b) >> n) & 1));
                check("add_cin", 64'(if8.add_cin), 64'(carry_in));
            end
            inj8 = (n == inj_bit);
            if (poke && n == 3) begin
                if8.op_a  = ~a;
                if8.op_b  = 8'($urandom);
                if8.cin   = ~c;
                if8.start = 1'b1;
            end else begin
                if8.start = 1'b0;
            end
            @(negedge clk);
        end
        inj8      = 1'b0;
        if8.start = 1'b0;
        check("done_latency", 64'(done_at), 64'(8));
        check("busy_cycles", 64'(busy_n), 64'(8));
        check("busy_at_done", 64'(if8.busy), 64'(0));
        check("result", 64'(if8.result), 64'(total & 8'hFF));
        check("cout", 64'(if8.cout), 64'((total >> 8) & 1));
        check("mismatch", 64'(if8.mismatch), 64'(exp_mm));
        @(negedge clk);
        check("done_one_cycle", 64'(if8.done), 64'(0));
        check("result_held", 64'(if8.result), 64'(total & 8'hFF));
        check("mismatch_held", 64'(if8.mismatch), 64'(exp_mm));
    endtask

    task automatic run1(input logic a, input logic b, input logic c);
        int total;
        total = int'(a) + int'(b) + int'(c);
        @(negedge clk);
        if1.op_a  = a;
        if1.op_b  = b;
        if1.cin   = c;
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        check("w1_busy", 64'(if1.busy), 64'(1));
        check("w1_done_early", 64'(if1.done), 64'(0));
        check("w1_add_cin", 64'(if1.add_cin), 64'(c));
        @(negedge clk);
        check("w1_done", 64'(if1.done), 64'(1));
        check("w1_result", 64'(if1.result), 64'(total & 1));
        check("w1_cout", 64'(if1.cout), 64'((total >> 1) & 1));
        @(negedge clk);
        check("w1_done_drop", 64'(if1.done), 64'(0));
    endtask

    initial begin
        int  inj;
        bit  saw_done;
        n_assert  = 0;
        n_fail    = 0;
        inj8      = 1'b0;
        rst       = 1'b1;
        if8.start = 1'b0;
        if8.op_a  = 8'hA5;
        if8.op_b  = 8'h3C;
        if8.cin   = 1'b1;
        if1.start = 1'b0;
        if1.op_a  = 1'b0;
        if1.op_b  = 1'b0;
        if1.cin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(if8.busy), 64'(0));
        check("rst_done", 64'(if8.done), 64'(0));
        check("rst_result", 64'(if8.result), 64'(0));
        check("rst_cout", 64'(if8.cout), 64'(0));
        check("rst_mismatch", 64'(if8.mismatch), 64'(0));
        check("rst_add", 64'({if8.add_a, if8.add_b, if8.add_cin}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        run8(8'h00, 8'h00, 1'b0, -1, 1'b0);
        run8(8'hFF, 8'h01, 1'b0, -1, 1'b0);
        run8(8'h5A, 8'h3C, 1'b1, -1, 1'b1);
        run8(8'h12, 8'h34, 1'b0, 3, 1'b0);
        run8(8'h12, 8'h34, 1'b0, -1, 1'b0);

        // Reset in the RUN cycle that processes bit 4.
        run8(8'hC3, 8'h7E, 1'b1, 6, 1'b0);
        @(negedge clk);
        if8.op_a  = 8'h9D;
        if8.op_b  = 8'h44;
        if8.cin   = 1'b0;
        if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(if8.busy), 64'(0));
        check("abort_done", 64'(if8.done), 64'(0));
        check("abort_result", 64'(if8.result), 64'(0));
        check("abort_cout", 64'(if8.cout), 64'(0));
        check("abort_mismatch", 64'(if8.mismatch), 64'(0));
        saw_done = 1'b0;
        for (int n = 0; n < 12; n++) begin
            if (if8.done || if8.busy) saw_done = 1'b1;
            @(negedge clk);
        end
        check("abort_no_done", 64'(saw_done), 64'(0));
        run8(8'h9D, 8'h44, 1'b0, -1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            run8(8'($urandom), 8'($urandom), 1'($urandom), inj, 1'($urandom));
        end

        run1(1'b1, 1'b1, 1'b1);
        run1(1'b0, 1'b0, 1'b1);
        run1(1'b1, 1'b0, 1'b0);
        run1(1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Sequencer that performs a WIDTH-bit addition by time-sharing one external 1-bit full-adder pair, the dual-implementation adder block with outputs Sum1/Cout1 and Sum2/Cout2. The block processes one bit per clock, LSB first, and holds the ripple carry in a flip-flop. It cross-checks both adder implementations on every bit and reports any disagreement. It sits between a requester (start/done handshake) and the combinational adder instance.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 1..32)

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  reset, synchronous, active-high
start  in  1  request pulse; sampled only in IDLE
op_a  in  WIDTH  operand A, captured on accepted start
op_b  in  WIDTH  operand B, captured on accepted start
cin  in  1  initial carry-in, captured on accepted start
busy  out  1  high while in RUN
done  out  1  one-cycle pulse when result is valid
result  out  WIDTH  sum, held from done until next accepted start
cout  out  1  final carry, held with result
mismatch  out  1  sticky: any bit where Sum1!=Sum2 or Cout1!=Cout2 during the operation
add_a  out  1  to adder DataA
add_b  out  1  to adder DataB
add_cin  out  1  to adder Cin
add_sum1, add_cout1  in  1 each  from adder implementation 1 (reference/primary)
add_sum2, add_cout2  in  1 each  from adder implementation 2 (checked)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port rst.
- Reset: state=IDLE; busy, done, result, cout, mismatch, add_a, add_b, add_cin all 0; internal shift registers, carry and bit counter cleared.
- FSM states:
  - IDLE: add_* driven 0. When start=1, capture op_a/op_b into shift regs and cin into the carry FF, set bit counter=0, clear mismatch, go to RUN.
  - RUN: busy=1. add_a=a_sh[0], add_b=b_sh[0], add_cin=carry (combinational from registers). Each edge:
    - shift sum1 into sum_sh from the MSB end (right shift);
    - carry<=add_cout1;
    - a_sh/b_sh shift right;
    - mismatch|=(add_sum1^add_sum2)|(add_cout1^add_cout2);
    - counter++.
    - On the edge where counter==WIDTH-1: result<=final sum_sh value including this bit, cout<=add_cout1; go to DONE.
  - DONE: done=1, busy=0 for exactly one cycle; unconditionally return to IDLE.
- Latency: start sampled at edge k, which enters RUN. The WIDTH RUN cycles end at edge k+WIDTH, which enters DONE. done is high in the cycle after edge k+WIDTH. Total WIDTH+1 cycles from start to done.
- start while RUN or DONE: ignored, no queuing.
- result/cout are updated only on the transition into DONE. Before the first operation they read 0, afterwards they hold the last value.
- mismatch: cleared on accepted start. It may rise during RUN and stays high until the next accepted start or rst. Primary (Sum1/Cout1) values are always used for result/cout.
- Arithmetic: {cout,result} = op_a + op_b + cin, modulo 2^(WIDTH+1). No overflow flag.
- rst mid-RUN: abort at that edge. No done pulse; outputs return to reset values.
- WIDTH=1: RUN lasts one cycle; done in the second cycle after start.

Test Plan:
1. WIDTH=8, op_a=0x00, op_b=0x00, cin=0 -> done 9 cycles after start; result=0x00, cout=0, mismatch=0; busy high for exactly 8 cycles.
2. op_a=0xFF, op_b=0x01, cin=0 -> result=0x00, cout=1. Carry ripples through all bits; add_cin=1 from bit 1 onward.
3. op_a=0x5A, op_b=0x3C, cin=1 -> result=0x97, cout=0. Then start a second pulse during busy with different operands -> ignored, result still 0x97.
4. Bench inverts add_sum2 during bit 3 only, operands 0x12+0x34 -> result=0x46 (from Sum1), mismatch=1 at done and still 1 after. The next clean start clears it to 0.
5. Assert rst for one cycle in the RUN cycle at counter=4 -> next cycle busy=0, done=0, result=0, cout=0. No done pulse follows; a new start completes normally.
6. WIDTH=1, op_a=1, op_b=1, cin=1 -> result=1, cout=1, done in the second cycle after start.
